fp_mul_sched: RTL and testbench
===============================

# fp_mul_sched

Round-robin scheduler that shares one single-precision floating-point multiplier (`fp_mul`) among N requesters. It accepts one operation at a time and holds operands and rounding mode stable on the multiplier for the whole computation. It then captures the result and exception flags and returns them to the winning requester over a valid/ready response channel tagged with the requester id. It sits between the FPU issue logic and the multiplier instance.

## Interface

Parameters:
- `N`, 4: number of requesters (2..8).
- `W`, 32: operand/result width.
- `LAT`, 2: multiplier register stages from stable inputs to valid `mul_out`.
- `IDW`, `$clog2(N)`: requester id width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in N: per-requester operation request.
- `req_ready` out N: one-hot grant/accept. Handshake happens when `req_valid[i] & req_ready[i]`.
- `req_a` in N*W: operand 1, requester i occupies bits [i*W +: W].
- `req_b` in N*W: operand 2, same packing.
- `req_rm` in N*3: rounding mode, requester i occupies bits [i*3 +: 3].
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: response consumer accepts.
- `rsp_id` out IDW: requester that owns the response.
- `rsp_data` out W: product.
- `rsp_flags` out 4: {inv, ov, un, inexact} as produced by the multiplier.
- `busy` out 1: high in every state except IDLE.
- `mul_in1`, `mul_in2` out W: multiplier operands, registered.
- `mul_round_m` out 3: multiplier rounding mode, registered.
- `mul_act` out 1: high while the multiplier is computing.
- `mul_out` in W, `mul_ov`/`mul_un`/`mul_inv`/`mul_inexact`/`mul_done` in 1: multiplier results.

## Operation

- **States:** IDLE, BUSY, RESP. Encoding is free.
- **IDLE:**
  - Grant goes to the first `i` with `req_valid[i]`, searching from `rr_ptr` upward and wrapping mod N.
  - `req_ready` is one-hot on that `i`, and all zeros if no request is valid. It is never asserted outside IDLE.
  - On handshake: latch `req_a[i]`, `req_b[i]`, `req_rm[i]` into `mul_in1`, `mul_in2`, `mul_round_m`. Latch the id `i`. Set `cnt=0` and go to BUSY.
- **BUSY:**
  - `mul_act=1`. Operands, rounding mode and id are frozen.
  - `cnt` increments each cycle. When `cnt==LAT`, capture `mul_out` and the flags into the response registers and go to RESP.
  - A low `mul_done` at capture is ignored. Capture timing is fixed by `LAT`.
- **RESP:**
  - `rsp_valid=1`. `rsp_id`, `rsp_data` and `rsp_flags` are stable until the handshake.
  - On `rsp_ready`: set `rr_ptr = (id+1) mod N` and go to IDLE.
  - `rsp_ready` low holds RESP indefinitely, with no new grants.
- **Requester protocol:** a requester holds `req_valid` and its operands until it sees `req_ready`. Deasserting `req_valid` in IDLE before a grant is legal; no handshake occurs.
- **Fairness:** any continuously valid requester is served within N operations.
- **`mul_in*` in IDLE:** the registers keep their last values, so unused multiplier toggling is avoided.
- **Reset:** applies at any time, including mid-BUSY or mid-RESP.
  - State goes to IDLE; `rr_ptr`, `cnt`, id and all registered outputs go to 0.
  - The in-flight operation is discarded with no response.
- **Reset values:** `req_ready=0` (valid-gated), `rsp_valid=0`, `rsp_id=0`, `rsp_data=0`, `rsp_flags=0`, `busy=0`, `mul_in1=0`, `mul_in2=0`, `mul_round_m=0`, `mul_act=0`.

## Timing

- Cycle 0: IDLE handshake.
- Cycles 1..LAT+1: BUSY, which lasts LAT+1 cycles. `mul_*` are stable from cycle 1. Capture occurs at the end of cycle LAT+1.
- Cycle LAT+2: `rsp_valid=1`. Accept-to-response latency is LAT+2 cycles (4 at default).
- If `rsp_ready` is high in cycle LAT+2, the scheduler is in IDLE in cycle LAT+3, where the next grant is possible. Minimum issue interval is LAT+3 cycles (5 at default).
- `req_ready` is combinational from `req_valid`, state and `rr_ptr`. No combinational path exists from `rsp_ready` to `req_ready`.
- **Simultaneous requests:** all N valid in the same cycle produce exactly one grant per IDLE visit.

## Test plan

- **Single op:** requester 0, `a=0x40400000`, `b=0x40000000`, `rm=RNe` -> `rsp_valid` 4 cycles after accept, `rsp_data=0x40C00000`, `rsp_flags=0`, `rsp_id=0`.
- **Round-robin:** all 4 `req_valid` held high from reset -> grant order 0,1,2,3,0,1. Each `req_ready` is one-hot and asserted only in IDLE. Issue interval is 5 cycles with `rsp_ready=1`.
- **Exception passthrough:** requester 2, `a=0x7F800000` (+inf), `b=0x00000000` -> `rsp_data` = codebase quiet NaN, `rsp_flags=4'b1000`, `rsp_id=2`.
- **Backpressure:** requester 1, `a=b=0x3FC00000`, with `rsp_ready` low for 6 cycles after `rsp_valid`.
  - `rsp_data=0x40100000` is held constant and `busy=1`.
  - `req_ready=0` throughout, even with requester 3 valid.
  - Requester 3 is granted in the first IDLE cycle after the handshake.
- **Reset mid-BUSY:** assert `rst` at cycle 2 after accept -> all outputs 0 immediately (asynchronous), and no response appears. After release, requester 0 is granted first (`rr_ptr=0`).
- **Withdrawn request:** requester 1 pulses `req_valid` for one cycle while BUSY for requester 0 -> no grant to 1; next IDLE grants only currently valid requesters.

Source files
------------

// File: rtl/fp_mul_sched_if.sv
// Issue and response channels between FPU requesters and the shared-multiplier scheduler.
// Operand and rounding-mode buses are packed with requester i in slot i.
interface fp_mul_sched_if #(
   parameter int N   = 4,
   parameter int W   = 32,
   parameter int IDW = $clog2(N)
);
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_a;
   logic [N*W-1:0] req_b;
   logic [N*3-1:0] req_rm;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [IDW-1:0] rsp_id;
   logic [W-1:0]   rsp_data;
   logic [3:0]     rsp_flags;

   modport master (
      output req_valid, req_a, req_b, req_rm, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_flags
   );

   modport slave (
      input  req_valid, req_a, req_b, req_rm, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_data, rsp_flags
   );
endinterface

// File: rtl/fp_mul_sched.sv
// Round-robin scheduler sharing one fixed-latency FP multiplier among N requesters.
// One operation is in flight at a time; the result is returned with the owner's id.
module fp_mul_sched #(
   parameter int N   = 4,
   parameter int W   = 32,
   parameter int LAT = 2,
   parameter int IDW = $clog2(N)
) (
   input  logic               clk,
   input  logic               rst,
   fp_mul_sched_if.slave      bus,
   output logic               busy,
   output logic [W-1:0]       mul_in1,
   output logic [W-1:0]       mul_in2,
   output logic [2:0]         mul_round_m,
   output logic               mul_act,
   input  logic [W-1:0]       mul_out,
   input  logic               mul_ov,
   input  logic               mul_un,
   input  logic               mul_inv,
   input  logic               mul_inexact,
   input  logic               mul_done
);
   localparam int CW = (LAT > 0) ? $clog2(LAT + 1) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t         state;
   logic [IDW-1:0] rr_ptr;
   logic [IDW-1:0] id;
   logic [CW-1:0]  cnt;
   logic           rsp_valid;
   logic [W-1:0]   rsp_data;
   logic [3:0]     rsp_flags;
   logic           grant_any;
   logic [IDW-1:0] grant_id;
   logic [IDW-1:0] idx;
   logic [W-1:0]   a_slot  [N];
   logic [W-1:0]   b_slot  [N];
   logic [2:0]     rm_slot [N];

   // Capture timing is fixed by LAT, so the multiplier's done strobe carries no information.
   logic unused_done;
   assign unused_done = mul_done;

   function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int k);
      logic [IDW:0] sum;
      sum = {1'b0, base} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(N)) sum = sum - (IDW+1)'(N);
      return sum[IDW-1:0];
   endfunction

   for (genvar k = 0; k < N; k++) begin : g_slot
      assign a_slot[k]  = bus.req_a[k*W +: W];
      assign b_slot[k]  = bus.req_b[k*W +: W];
      assign rm_slot[k] = bus.req_rm[k*3 +: 3];
   end

   // First valid requester at or after rr_ptr, wrapping mod N.
   always_comb begin
      grant_any = 1'b0;
      grant_id  = '0;
      idx       = '0;
      for (int k = 0; k < N; k++) begin
         idx = wrap_add(rr_ptr, k);
         if (!grant_any && bus.req_valid[idx]) begin
            grant_any = 1'b1;
            grant_id  = idx;
         end
      end
   end

   assign bus.req_ready = (state == IDLE && grant_any) ? ({{(N-1){1'b0}}, 1'b1} << grant_id) : '0;
   assign bus.rsp_valid = rsp_valid;
   assign bus.rsp_id    = id;
   assign bus.rsp_data  = rsp_data;
   assign bus.rsp_flags = rsp_flags;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         id          <= '0;
         cnt         <= '0;
         busy        <= 1'b0;
         mul_act     <= 1'b0;
         mul_in1     <= '0;
         mul_in2     <= '0;
         mul_round_m <= '0;
         rsp_valid   <= 1'b0;
         rsp_data    <= '0;
         rsp_flags   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_any) begin
                  mul_in1     <= a_slot[grant_id];
                  mul_in2     <= b_slot[grant_id];
                  mul_round_m <= rm_slot[grant_id];
                  id          <= grant_id;
                  cnt         <= '0;
                  busy        <= 1'b1;
                  mul_act     <= 1'b1;
                  state       <= BUSY;
               end
            end
            BUSY: begin
               if (cnt == CW'(LAT)) begin
                  rsp_data  <= mul_out;
                  rsp_flags <= {mul_inv, mul_ov, mul_un, mul_inexact};
                  rsp_valid <= 1'b1;
                  mul_act   <= 1'b0;
                  state     <= RESP;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid <= 1'b0;
                  busy      <= 1'b0;
                  rr_ptr    <= wrap_add(id, 1);
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fp_mul_sched.sv
// Directed bench for fp_mul_sched with a fixed-latency multiplier model.
module tb_fp_mul_sched;
   localparam int N   = 4;
   localparam int W   = 32;
   localparam int LAT = 2;
   localparam int IDW = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fp_mul_sched_if #(.N(N), .W(W), .IDW(IDW)) bus ();

   logic         busy, mul_act, mul_ov, mul_un, mul_inv, mul_inexact, mul_done;
   logic [W-1:0] mul_in1, mul_in2, mul_out;
   logic [2:0]   mul_round_m;
   logic [35:0]  pipe0, pipe1;
   logic         done0, done1;
   int           n_tests = 0;
   int           n_fail = 0;
   int           cyc = 0;
   int           last_cyc;
   int           rr_exp [6] = '{0, 1, 2, 3, 0, 1};
   logic [31:0]  rra [4] = '{32'h11110001, 32'h22220012, 32'h33330123, 32'h44441234};
   logic [31:0]  rrb [4] = '{32'h0F0F5555, 32'hF0F06666, 32'h12347777, 32'h87658888};
   logic         seen_rsp;

   fp_mul_sched #(.N(N), .W(W), .LAT(LAT), .IDW(IDW)) dut (
      .clk(clk), .rst(rst), .bus(bus), .busy(busy),
      .mul_in1(mul_in1), .mul_in2(mul_in2), .mul_round_m(mul_round_m), .mul_act(mul_act),
      .mul_out(mul_out), .mul_ov(mul_ov), .mul_un(mul_un), .mul_inv(mul_inv),
      .mul_inexact(mul_inexact), .mul_done(mul_done)
   );

   // Multiplier model: {product, inv, ov, un, inexact}; unlisted pairs map to a fixed scramble.
   function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
      case ({a, b})
         {32'h40400000, 32'h40000000}: return {32'h40C00000, 4'b0000};
         {32'h7F800000, 32'h00000000}: return {32'h7FC00000, 4'b1000};
         {32'h3FC00000, 32'h3FC00000}: return {32'h40100000, 4'b0000};
         {32'h3F800000, 32'h40000000}: return {32'h40000000, 4'b0000};
         {32'h40000000, 32'hC0400000}: return {32'hC0C00000, 4'b0000};
         default:                      return {a[15:0] ^ b[31:16], b[15:0], a[3:0]};
      endcase
   endfunction

   always @(posedge clk) begin
      pipe0 <= ref_mul(mul_in1, mul_in2);
      pipe1 <= pipe0;
      done0 <= mul_act;
      done1 <= done0;
      cyc   <= cyc + 1;
   end
   assign mul_out = pipe1[35:4];
   assign {mul_inv, mul_ov, mul_un, mul_inexact} = pipe1[3:0];
   assign mul_done = done1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm);
      bus.req_a[r*W +: W] = a;
      bus.req_b[r*W +: W] = b;
      bus.req_rm[r*3 +: 3] = rm;
   endtask

   // Starts one op from IDLE with only requester r valid; ends #1 after the response handshake.
   task automatic run_op(input string tag, input int r, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] rm, input logic [31:0] ed, input logic [3:0] ef);
      set_req(r, a, b, rm);
      bus.req_valid = bus.req_valid | (N'(1) << r);
      @(negedge clk);
      chk({tag, ".grant"}, 64'(bus.req_ready), 64'(N'(1) << r));
      @(posedge clk); #1;
      bus.req_valid = bus.req_valid & ~(N'(1) << r);
      for (int c = 1; c <= LAT + 1; c++) begin
         @(negedge clk);
         chk({tag, ".busy"}, 64'({busy, mul_act, bus.rsp_valid, bus.req_ready}), 64'({2'b11, 1'b0, 4'b0000}));
      end
      chk({tag, ".mul_in"}, {mul_in1, mul_in2}, {a, b});
      chk({tag, ".rm"}, 64'(mul_round_m), 64'(rm));
      @(negedge clk);
      chk({tag, ".rsp"}, 64'({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_flags}),
          64'({1'b1, IDW'(r), ed, ef}));
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      bus.req_valid = '0;
      bus.req_a = '0;
      bus.req_b = '0;
      bus.req_rm = '0;
      bus.rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst.req_ready", 64'(bus.req_ready), 64'(0));
      chk("rst.rsp", 64'({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_flags}), 64'(0));
      chk("rst.ctl", 64'({busy, mul_act, mul_round_m}), 64'(0));
      chk("rst.mul_in", {mul_in1, mul_in2}, 64'(0));
      rst = 1'b0;
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;

      run_op("single", 0, 32'h40400000, 32'h40000000, 3'b000, 32'h40C00000, 4'b0000);
      run_op("exc", 2, 32'h7F800000, 32'h00000000, 3'b001, 32'h7FC00000, 4'b1000);

      // Backpressure: response held for 6 cycles while requester 3 waits.
      bus.rsp_ready = 1'b0;
      set_req(1, 32'h3FC00000, 32'h3FC00000, 3'b010);
      set_req(3, 32'h5A5A0F0F, 32'h0000C3C3, 3'b011);
      bus.req_valid = 4'b0010;
      @(negedge clk);
      chk("bp.grant", 64'(bus.req_ready), 64'(4'b0010));
      @(posedge clk); #1;
      bus.req_valid = 4'b0000;
      repeat (LAT + 1) @(posedge clk);
      #1;
      bus.req_valid = 4'b1000;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("bp.hold", 64'({bus.rsp_valid, busy, bus.req_ready, bus.rsp_id, bus.rsp_data, bus.rsp_flags}),
             64'({2'b11, 4'b0000, 2'd1, 32'h40100000, 4'b0000}));
         @(posedge clk); #1;
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp.no_ready_in_resp", 64'(bus.req_ready), 64'(0));
      @(posedge clk); #1;
      run_op("bp.r3", 3, 32'h5A5A0F0F, 32'h0000C3C3, 3'b011,
             ref_mul(32'h5A5A0F0F, 32'h0000C3C3) >> 4, ref_mul(32'h5A5A0F0F, 32'h0000C3C3) & 36'hF);

      // Withdrawn request: requester 1 pulses during BUSY, requester 2 arrives and stays.
      set_req(0, 32'h3F800000, 32'h40000000, 3'b000);
      set_req(2, 32'h40000000, 32'hC0400000, 3'b100);
      bus.req_valid = 4'b0001;
      @(negedge clk);
      chk("wd.grant0", 64'(bus.req_ready), 64'(4'b0001));
      @(posedge clk); #1;
      bus.req_valid = 4'b0010;
      @(negedge clk);
      chk("wd.pulse_no_grant", 64'(bus.req_ready), 64'(0));
      @(posedge clk); #1;
      bus.req_valid = 4'b0100;
      repeat (LAT) @(posedge clk);
      @(negedge clk);
      chk("wd.rsp0", 64'({bus.rsp_valid, bus.rsp_id, bus.rsp_data}), 64'({1'b1, 2'd0, 32'h40000000}));
      @(negedge clk);
      chk("wd.grant2", 64'(bus.req_ready), 64'(4'b0100));
      @(posedge clk); #1;
      bus.req_valid = 4'b0000;
      repeat (LAT + 1) @(posedge clk);
      @(negedge clk);
      chk("wd.rsp2", 64'({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_flags}),
          64'({1'b1, 2'd2, 32'hC0C00000, 4'b0000}));
      @(posedge clk); #1;

      // Reset in the middle of BUSY discards the operation.
      set_req(1, 32'h3FC00000, 32'h40000000, 3'b111);
      bus.req_valid = 4'b0010;
      @(negedge clk);
      chk("rstm.grant", 64'(bus.req_ready), 64'(4'b0010));
      @(posedge clk); #1;
      bus.req_valid = 4'b0000;
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      chk("rstm.rsp", 64'({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_flags}), 64'(0));
      chk("rstm.ctl", 64'({busy, mul_act, mul_round_m}), 64'(0));
      chk("rstm.mul_in", {mul_in1, mul_in2}, 64'(0));
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      seen_rsp = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         seen_rsp = seen_rsp | bus.rsp_valid | busy;
      end
      chk("rstm.no_rsp", 64'(seen_rsp), 64'(0));

      // Round-robin with all requesters continuously valid.
      for (int i = 0; i < N; i++) set_req(i, rra[i], rrb[i], 3'(i));
      @(posedge clk); #1;
      bus.req_valid = 4'b1111;
      last_cyc = 0;
      for (int g = 0; g < 6; g++) begin
         int waited;
         waited = 0;
         @(negedge clk);
         while (bus.req_ready == '0 && waited < 20) begin
            @(negedge clk);
            waited++;
         end
         chk("rr.grant", 64'(bus.req_ready), 64'(N'(1) << rr_exp[g]));
         if (g > 0) chk("rr.interval", 64'(cyc - last_cyc), 64'(LAT + 3));
         last_cyc = cyc;
         for (int c = 1; c <= LAT + 2; c++) begin
            @(negedge clk);
            if (c <= LAT + 1) chk("rr.no_ready", 64'(bus.req_ready), 64'(0));
         end
         chk("rr.rsp", 64'({bus.rsp_valid, bus.rsp_id, ref_mul(rra[rr_exp[g]], rrb[rr_exp[g]]) == {bus.rsp_data, bus.rsp_flags}}),
             64'({1'b1, IDW'(rr_exp[g]), 1'b1}));
      end
      bus.req_valid = 4'b0000;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
